pet_io_fabric: RTL and testbench
================================

// Module: pet_io_fabric
// PURPOSE
//  Parametrised I/O bus fabric for the PET I/O page, the successor to the fixed PIA/VIA/CRTC decoder.
//  Decodes NSLOTS base/mask windows and issues one-cycle device strobes.
//  Waits for per-slot acks, bounded by a timeout, and registers the wired-AND read data.
//  Drives the CPU RDY handshake and aggregates per-slot IRQs (level or latched-edge).
// PARAMETERS
//  NSLOTS     4                    number of device slots
//  AW         8                    I/O page address width
//  DW         8                    data width
//  SLOT_BASE  {8'h80,8'h40,8'h20,8'h10}  packed NSLOTS*AW; slot i match when (addr&MASK_i)==BASE_i
//  SLOT_MASK  {8'h80,8'h40,8'h20,8'h10}  packed NSLOTS*AW decode masks (partial decode allowed)
//  IRQ_EDGE   4'b0000              bit i=1: slot i IRQ latched on rising edge; 0: level pass-through
//  TIMEOUT    15                   max WAIT cycles before forced completion; width $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1         system clock
//  reset        in   1         synchronous, active-high reset
//  ce           in   1         CPU clock enable; access sampled only when ce=1
//  cs           in   1         I/O page select from CPU decode
//  we           in   1         1=write, 0=read
//  addr         in   AW        I/O page offset
//  data_in      in   DW        CPU write data
//  data_out     out  DW        registered read data
//  rdy          out  1         1-cycle pulse: access complete, data_out valid
//  bus_err      out  1         sticky; set on timeout, cleared by reset only
//  slot_strobe  out  NSLOTS    one-cycle strobe per matching slot
//  slot_we      out  1         registered copy of we during strobe/wait
//  slot_addr    out  AW        registered copy of addr, held IDLE->DONE
//  slot_wdata   out  DW        registered copy of data_in, held IDLE->DONE
//  slot_rdata   in   NSLOTS*DW per-slot read data, valid with ack
//  slot_ack     in   NSLOTS    per-slot completion (zero-wait devices tie 1)
//  slot_irq     in   NSLOTS    per-slot interrupt request, active high
//  irq_en       in   NSLOTS    per-slot interrupt enable
//  irq          out  1         OR of enabled pending sources
//  irq_pend     out  NSLOTS    pending vector: level value or edge latch
// BEHAVIOUR
//  Reset: state=IDLE; data_out=all 1s; rdy=0; bus_err=0; slot_strobe=0; slot_we=0; slot_addr=0;
//   slot_wdata=0; edge latches=0; timeout counter=0.
//  FSM states: IDLE, STROBE, WAIT, DONE.
//  IDLE: if ce&cs, latch addr/we/data_in and the match vector sel[i] -> STROBE.
//   cs with no match: -> DONE directly, data_out=all 1s, no strobe.
//  STROBE: slot_strobe=sel for exactly one cycle; clear counter -> WAIT.
//  WAIT: done when (slot_ack|~sel)=all 1s -> DONE.
//   Otherwise counter++; when counter==TIMEOUT -> DONE, set bus_err, read data=all 1s.
//  DONE: rdy=1 for one cycle -> IDLE. New access accepted next cycle at earliest.
//  Read data: data_out <= AND over i of (sel[i] ? slot_rdata[i] : all 1s), captured on the WAIT->DONE cycle.
//   Multi-match is legal (wired-AND, mirrors PET partial decode); the fabric waits for every selected ack.
//  Writes: data_out unchanged; rdy still pulses.
//  Latency: zero-wait slot read = rdy 3 cycles after ce&cs sampled (STROBE, WAIT, DONE).
//  ce is ignored outside IDLE; cs deassert mid-access does not abort the access.
//  IRQ level slots: irq_pend[i]=slot_irq[i] (registered, 1 cycle).
//  IRQ edge slots: latch sets on 0->1 of slot_irq[i]; clears on a slot_strobe[i] read.
//   If a set and a clear coincide, set wins.
//  irq = |(irq_pend & irq_en), registered. irq_en=0 masks the output but keeps irq_pend.
//  Reset mid-access: immediate IDLE; no rdy pulse; strobes drop the same cycle.
// STRUCTURE
//  pet_io_pkg: FSM state enum, IO_ST_* localparams, all-1s constant, slot_match() function.
//  One sub-module pet_irq_agg (per-slot edge/level latch plus mask/OR); FSM and read mux live in top.
// TESTING
//  1 Read slot1 (base 0x20), ack tied 1, rdata=0x5A: strobe[1] one cycle; rdy 3 cycles after; data_out=0x5A.
//  2 addr=0x30, slots 0 and 1 match, rdata 0xF0/0x3C: both strobes; data_out=0x30.
//  3 Slot2 ack held 0, TIMEOUT=15: rdy at WAIT count 15; data_out=0xFF; bus_err=1 and stays 1.
//  4 Slot3 ack after 5 WAIT cycles, write 0xA5: slot_wdata=0xA5 held to DONE; data_out unchanged.
//  5 IRQ_EDGE[0]=1: pulse slot_irq[0] -> irq=1 held; read slot0 -> pend clears. Coinciding edge -> stays set.
//  6 reset asserted in WAIT: next cycle IDLE, strobes 0, no rdy, data_out=0xFF; next access completes normally.

Source files
------------

// File: rtl/pet_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pet_io_pkg
//  Description : Shared types and helpers for the PET I/O bus fabric:
//                FSM state encoding, all-ones constant, slot decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pet_io_pkg;

  localparam logic [1:0] IO_ST_IDLE   = 2'd0;
  localparam logic [1:0] IO_ST_STROBE = 2'd1;
  localparam logic [1:0] IO_ST_WAIT   = 2'd2;
  localparam logic [1:0] IO_ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IO_ST_IDLE,
    ST_STROBE = IO_ST_STROBE,
    ST_WAIT   = IO_ST_WAIT,
    ST_DONE   = IO_ST_DONE
  } io_state_e;

  // Widest address/data the helpers handle; callers zero-extend into it.
  localparam int unsigned IO_MAX_W = 32;
  localparam logic [IO_MAX_W-1:0] IO_ALL_ONES = '1;

  // A slot claims the access when the masked address equals its base.
  function automatic logic slot_match(input logic [IO_MAX_W-1:0] addr,
                                      input logic [IO_MAX_W-1:0] base,
                                      input logic [IO_MAX_W-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pet_io_fabric_if.sv
`default_nettype none
// ============================================================================
//  Module      : pet_io_fabric_if
//  Description : CPU-side access, device-slot and interrupt signals of the
//                PET I/O fabric. The fabric uses the slave view; the CPU and
//                device side together form the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pet_io_fabric_if #(
  parameter int NSLOTS = 4,
  parameter int AW     = 8,
  parameter int DW     = 8
);
  logic                 ce;
  logic                 cs;
  logic                 we;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        data_in;
  logic [DW-1:0]        data_out;
  logic                 rdy;
  logic                 bus_err;
  logic [NSLOTS-1:0]    slot_strobe;
  logic                 slot_we;
  logic [AW-1:0]        slot_addr;
  logic [DW-1:0]        slot_wdata;
  logic [NSLOTS*DW-1:0] slot_rdata;
  logic [NSLOTS-1:0]    slot_ack;
  logic [NSLOTS-1:0]    slot_irq;
  logic [NSLOTS-1:0]    irq_en;
  logic                 irq;
  logic [NSLOTS-1:0]    irq_pend;

  modport master (
    output ce, cs, we, addr, data_in, slot_rdata, slot_ack, slot_irq, irq_en,
    input  data_out, rdy, bus_err, slot_strobe, slot_we, slot_addr, slot_wdata,
           irq, irq_pend
  );

  modport slave (
    input  ce, cs, we, addr, data_in, slot_rdata, slot_ack, slot_irq, irq_en,
    output data_out, rdy, bus_err, slot_strobe, slot_we, slot_addr, slot_wdata,
           irq, irq_pend
  );
endinterface
`default_nettype wire

// File: rtl/pet_irq_agg.sv
`default_nettype none
// ============================================================================
//  Module      : pet_irq_agg
//  Description : Per-slot interrupt pending logic (level pass-through or
//                rising-edge latch cleared by a read strobe) plus the masked
//                OR that forms the CPU interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module pet_irq_agg #(
  parameter int                NSLOTS   = 4,
  parameter logic [NSLOTS-1:0] IRQ_EDGE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSLOTS-1:0] slot_irq_i,
  input  logic [NSLOTS-1:0] irq_en_i,
  input  logic [NSLOTS-1:0] rd_clr_i,
  output logic [NSLOTS-1:0] irq_pend_o,
  output logic              irq_o
);

  logic [NSLOTS-1:0] prev_q;
  logic [NSLOTS-1:0] pend_q;
  logic [NSLOTS-1:0] pend_d;
  logic              irq_q;

  // Next pending value: edge slots set on 0->1 (set beats a coincident clear),
  // level slots simply follow the request line.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (IRQ_EDGE[i]) begin
        pend_d[i] = (slot_irq_i[i] & ~prev_q[i]) | (pend_q[i] & ~rd_clr_i[i]);
      end else begin
        pend_d[i] = slot_irq_i[i];
      end
    end
  end

  // Pending latches, edge history and the registered masked OR.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= slot_irq_i;
      pend_q <= pend_d;
      irq_q  <= |(pend_d & irq_en_i);
    end
  end

  assign irq_pend_o = pend_q;
  assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: rtl/pet_io_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : pet_io_fabric
//  Description : PET I/O page fabric. Decodes base/mask slot windows, issues
//                one-cycle device strobes, waits for acks (bounded by a
//                timeout), registers wired-AND read data and pulses rdy.
//  Revision    : 1.0 - initial release
// ============================================================================
module pet_io_fabric
  import pet_io_pkg::*;
#(
  parameter int                   NSLOTS    = 4,
  parameter int                   AW        = 8,
  parameter int                   DW        = 8,
  parameter logic [NSLOTS*AW-1:0] SLOT_BASE = {8'h80, 8'h40, 8'h20, 8'h10},
  parameter logic [NSLOTS*AW-1:0] SLOT_MASK = {8'h80, 8'h40, 8'h20, 8'h10},
  parameter logic [NSLOTS-1:0]    IRQ_EDGE  = '0,
  parameter int                   TIMEOUT   = 15
) (
  input  logic           clk,
  input  logic           reset,
  pet_io_fabric_if.slave bus
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LIMIT = CW'(TIMEOUT);
  localparam logic [DW-1:0]  ONES     = IO_ALL_ONES[DW-1:0];

  io_state_e         state_q, state_d;
  logic [NSLOTS-1:0] sel_q, sel_d, match;
  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rd_and;
  logic              acks_done;
  logic [NSLOTS-1:0] strobe;
  logic              rdy;

  generate
    for (genvar i = 0; i < NSLOTS; i++) begin : g_match
      assign match[i] = slot_match(IO_MAX_W'(bus.addr),
                                   IO_MAX_W'(SLOT_BASE[i*AW +: AW]),
                                   IO_MAX_W'(SLOT_MASK[i*AW +: AW]));
    end
  endgenerate

  // Wired-AND of the selected slots' read data; unselected slots float high.
  always_comb begin
    rd_and = ONES;
    for (int i = 0; i < NSLOTS; i++) begin
      if (sel_q[i]) rd_and = rd_and & bus.slot_rdata[i*DW +: DW];
    end
  end

  assign acks_done = &(bus.slot_ack | ~sel_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus datapath updates for the access in flight.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ce && bus.cs) begin
          addr_d  = bus.addr;
          we_d    = bus.we;
          wdata_d = bus.data_in;
          sel_d   = match;
          if (|match) begin
            state_d = ST_STROBE;
          end else begin
            // Unclaimed address: complete at once, read floats high.
            state_d = ST_DONE;
            if (!bus.we) dout_d = ONES;
          end
        end
      end
      ST_STROBE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (acks_done) begin
          state_d = ST_DONE;
          if (!we_q) dout_d = rd_and;
        end else if (cnt_q == TO_LIMIT) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (!we_q) dout_d = ONES;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe and completion outputs decoded from the current state.
  always_comb begin
    strobe = (state_q == ST_STROBE) ? sel_q : '0;
    rdy    = (state_q == ST_DONE);
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      dout_q  <= ONES;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  pet_irq_agg #(
    .NSLOTS   (NSLOTS),
    .IRQ_EDGE (IRQ_EDGE)
  ) u_irq_agg (
    .clk        (clk),
    .reset      (reset),
    .slot_irq_i (bus.slot_irq),
    .irq_en_i   (bus.irq_en),
    .rd_clr_i   (strobe & {NSLOTS{~we_q}}),
    .irq_pend_o (bus.irq_pend),
    .irq_o      (bus.irq)
  );

  assign bus.data_out    = dout_q;
  assign bus.rdy         = rdy;
  assign bus.bus_err     = err_q;
  assign bus.slot_strobe = strobe;
  assign bus.slot_we     = we_q;
  assign bus.slot_addr   = addr_q;
  assign bus.slot_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pet_io_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pet_io_fabric
//  Description : Scoreboard bench for pet_io_fabric with randomized accesses,
//                a transaction-level expectation model and IRQ checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pet_io_fabric;

  localparam int                NSLOTS   = 4;
  localparam int                AW       = 8;
  localparam int                DW       = 8;
  localparam int                TIMEOUT  = 15;
  localparam logic [NSLOTS*AW-1:0] BASE  = {8'h80, 8'h40, 8'h20, 8'h10};
  localparam logic [NSLOTS*AW-1:0] MASK  = {8'h80, 8'h40, 8'h20, 8'h10};
  localparam logic [NSLOTS-1:0] IRQ_EDGE = 4'b0101;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pet_io_fabric_if #(.NSLOTS(NSLOTS), .AW(AW), .DW(DW)) bus ();

  pet_io_fabric #(
    .NSLOTS(NSLOTS), .AW(AW), .DW(DW), .SLOT_BASE(BASE), .SLOT_MASK(MASK),
    .IRQ_EDGE(IRQ_EDGE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Device model: each slot acks ack_dly cycles into WAIT after its strobe.
  int ack_dly [NSLOTS];
  int wcnt    [NSLOTS];
  always @(posedge clk) begin
    for (int i = 0; i < NSLOTS; i++) begin
      if (bus.slot_strobe[i])  wcnt[i] <= 0;
      else if (wcnt[i] < 1000) wcnt[i] <= wcnt[i] + 1;
    end
  end
  always_comb begin
    bus.slot_ack = '0;
    for (int i = 0; i < NSLOTS; i++) bus.slot_ack[i] = (wcnt[i] >= ack_dly[i]);
  end

  // Free-running IRQ reference (no read clears; used before any access).
  logic [NSLOTS-1:0] pend_m, prev_m;
  logic              irq_m;
  function automatic logic [NSLOTS-1:0] nxt_pend(input logic [NSLOTS-1:0] p,
                                                 input logic [NSLOTS-1:0] s,
                                                 input logic [NSLOTS-1:0] pr);
    logic [NSLOTS-1:0] n;
    for (int i = 0; i < NSLOTS; i++) n[i] = IRQ_EDGE[i] ? (p[i] | (s[i] & ~pr[i])) : s[i];
    return n;
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      pend_m <= '0; prev_m <= '0; irq_m <= 1'b0;
    end else begin
      pend_m <= nxt_pend(pend_m, bus.slot_irq, prev_m);
      irq_m  <= |(nxt_pend(pend_m, bus.slot_irq, prev_m) & bus.irq_en);
      prev_m <= bus.slot_irq;
    end
  end

  // Scoreboard entries: what the DUT must show on its rdy cycle.
  typedef struct {
    logic [NSLOTS-1:0] sel;
    int                lat;
    logic              we;
    logic [DW-1:0]     dout;
    logic              err;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    longint            t0;
  } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] m_dout;
  logic          m_err;

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit irq_at_strobe);
    exp_t          e;
    int            worst;
    logic [DW-1:0] rd;
    e.sel = '0; worst = 0; rd = '1;
    for (int i = 0; i < NSLOTS; i++) begin
      if ((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        e.sel[i] = 1'b1;
        if (ack_dly[i] > worst) worst = ack_dly[i];
        rd &= bus.slot_rdata[i*DW +: DW];
      end
    end
    if (e.sel == '0) begin
      e.lat = 1;
      if (!w) m_dout = '1;
    end else if (worst > TIMEOUT) begin
      e.lat = TIMEOUT + 3;
      m_err = 1'b1;
      if (!w) m_dout = '1;
    end else begin
      e.lat = worst + 3;
      if (!w) m_dout = rd;
    end
    e.dout = m_dout; e.err = m_err; e.we = w; e.addr = a; e.wdata = d;
    @(negedge clk);
    if ($urandom_range(0, 1) == 1) begin
      bus.cs = 1'b1; bus.ce = 1'b0; bus.addr = a; bus.we = w; bus.data_in = d;
      @(negedge clk);
    end
    bus.cs = 1'b1; bus.ce = 1'b1; bus.addr = a; bus.we = w; bus.data_in = d;
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.ce = 1'b0; bus.cs = 1'($urandom_range(0, 1));
    bus.addr = 8'($urandom); bus.data_in = 8'($urandom); bus.we = 1'($urandom_range(0, 1));
    if (irq_at_strobe) bus.slot_irq[0] = 1'b1;
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
  endtask

  // Monitor: pops one expectation per rdy pulse.
  initial begin : monitor
    logic [NSLOTS-1:0] strb_seen;
    int                strb_cyc;
    exp_t              e;
    strb_seen = '0; strb_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        strb_seen = '0; strb_cyc = 0;
      end else begin
        if (bus.slot_strobe != '0) begin
          strb_seen |= bus.slot_strobe;
          strb_cyc++;
        end
        if (bus.rdy) begin
          if (sb.size() == 0) begin
            chk("spurious_rdy", 64'(bus.rdy), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("latency",     64'(cyc - e.t0), 64'(e.lat));
            chk("strobe_sel",  64'(strb_seen), 64'(e.sel));
            chk("strobe_cyc",  64'(strb_cyc), (e.sel != '0) ? 64'd1 : 64'd0);
            chk("data_out",    64'(bus.data_out), 64'(e.dout));
            chk("bus_err",     64'(bus.bus_err), 64'(e.err));
            chk("slot_addr",   64'(bus.slot_addr), 64'(e.addr));
            chk("slot_wdata",  64'(bus.slot_wdata), 64'(e.wdata));
            chk("slot_we",     64'(bus.slot_we), 64'(e.we));
          end
          strb_seen = '0; strb_cyc = 0;
        end else if (sb.size() != 0 && (cyc - sb[0].t0) > 40) begin
          chk("rdy_timeout", 64'd0, 64'd1);
          void'(sb.pop_front());
          strb_seen = '0; strb_cyc = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.ce = 1'b0; bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
    bus.slot_rdata = '0; bus.slot_irq = '0; bus.irq_en = '1;
    for (int i = 0; i < NSLOTS; i++) ack_dly[i] = 0;
    m_dout = '1; m_err = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_data_out",   64'(bus.data_out), 64'hFF);
    chk("rst_rdy",        64'(bus.rdy), 64'd0);
    chk("rst_bus_err",    64'(bus.bus_err), 64'd0);
    chk("rst_strobe",     64'(bus.slot_strobe), 64'd0);
    chk("rst_slot_we",    64'(bus.slot_we), 64'd0);
    chk("rst_slot_addr",  64'(bus.slot_addr), 64'd0);
    chk("rst_slot_wdata", 64'(bus.slot_wdata), 64'd0);
    chk("rst_irq_pend",   64'(bus.irq_pend), 64'd0);
    chk("rst_irq",        64'(bus.irq), 64'd0);

    // Random IRQ traffic against the free-running reference.
    repeat (40) begin
      @(negedge clk);
      chk("irq_pend_rand", 64'(bus.irq_pend), 64'(pend_m));
      chk("irq_rand",      64'(bus.irq), 64'(irq_m));
      bus.slot_irq = 4'($urandom);
      bus.irq_en   = 4'($urandom);
    end
    @(negedge clk);
    bus.slot_irq = '0; bus.irq_en = '1;

    // Zero-wait read of slot1.
    bus.slot_rdata = 32'($urandom); bus.slot_rdata[15:8] = 8'h5A;
    issue(1'b0, 8'h20, 8'h00, 1'b0);
    // Double match, wired-AND.
    bus.slot_rdata[7:0] = 8'hF0; bus.slot_rdata[15:8] = 8'h3C;
    issue(1'b0, 8'h30, 8'h00, 1'b0);
    // Ack on the last allowed WAIT count: completes without error.
    ack_dly[1] = TIMEOUT; bus.slot_rdata[15:8] = 8'h77;
    issue(1'b0, 8'h20, 8'h00, 1'b0);
    ack_dly[1] = 0;
    // Unclaimed address.
    issue(1'b0, 8'h05, 8'h00, 1'b0);
    // Write to slot3 with 5 wait cycles.
    ack_dly[3] = 5;
    issue(1'b1, 8'h80, 8'hA5, 1'b0);
    ack_dly[3] = 0;
    // Slot2 never acks: timeout, bus_err sticky.
    ack_dly[2] = 1000;
    issue(1'b0, 8'h40, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("bus_err_sticky", 64'(bus.bus_err), 64'd1);

    // Reset in the middle of WAIT.
    @(negedge clk);
    bus.cs = 1'b1; bus.ce = 1'b1; bus.addr = 8'h40; bus.we = 1'b0;
    @(negedge clk);
    bus.cs = 1'b0; bus.ce = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rdy",      64'(bus.rdy), 64'd0);
    chk("midrst_strobe",   64'(bus.slot_strobe), 64'd0);
    chk("midrst_data_out", 64'(bus.data_out), 64'hFF);
    chk("midrst_bus_err",  64'(bus.bus_err), 64'd0);
    reset = 1'b0; m_dout = '1; m_err = 1'b0; ack_dly[2] = 0;
    repeat (3) @(negedge clk);
    issue(1'b0, 8'h20, 8'h00, 1'b0);

    // Randomized accesses with random ack delays around the timeout.
    repeat (60) begin
      for (int i = 0; i < NSLOTS; i++)
        ack_dly[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 17))
                                                 : int'($urandom_range(0, 3));
      bus.slot_rdata = 32'($urandom);
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0);
    end
    for (int i = 0; i < NSLOTS; i++) ack_dly[i] = 0;

    // Edge-latched IRQ on slot0.
    bus.slot_irq = '0; bus.irq_en = 4'b0001;
    issue(1'b0, 8'h10, 8'h00, 1'b0);
    @(negedge clk);
    chk("irq0_cleared_init", 64'(bus.irq_pend[0]), 64'd0);
    bus.slot_irq[0] = 1'b1;
    @(negedge clk);
    bus.slot_irq[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("irq0_pend_held", 64'(bus.irq_pend[0]), 64'd1);
    chk("irq0_out_held",  64'(bus.irq), 64'd1);
    bus.irq_en = '0;
    repeat (2) @(negedge clk);
    chk("irq_masked",      64'(bus.irq), 64'd0);
    chk("irq_masked_pend", 64'(bus.irq_pend[0]), 64'd1);
    bus.irq_en = 4'b0001;
    @(negedge clk);
    chk("irq_unmasked", 64'(bus.irq), 64'd1);
    issue(1'b0, 8'h10, 8'h00, 1'b0);
    @(negedge clk);
    chk("irq0_read_clear", 64'(bus.irq_pend[0]), 64'd0);
    chk("irq0_out_clear",  64'(bus.irq), 64'd0);
    bus.slot_irq[0] = 1'b1;
    @(negedge clk);
    bus.slot_irq[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq0_repend", 64'(bus.irq_pend[0]), 64'd1);
    issue(1'b0, 8'h10, 8'h00, 1'b1);
    @(negedge clk);
    chk("irq0_set_wins", 64'(bus.irq_pend[0]), 64'd1);
    bus.slot_irq = '0;

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
